// File: rtl/xbus_arb.sv
// Data-memory port arbiter: the CPU has fixed priority, and the host is served in CPU idle cycles.
// A starvation counter forces a one-cycle CPU hold, so the host is served within STARVE_MAX+2 cycles.
module xbus_arb #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_sel,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD, ST_DONE} state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                host_ack_reg;
    logic [DATA_W-1:0]   host_rdata_reg;
    logic                lat_we_reg;
    logic [ADDR_W-1:0]   lat_addr_reg;
    logic [DATA_W-1:0]   lat_wdata_reg;
    logic                grant_host;

    assign grant_host = ((state_reg == ST_WAIT) && !cpu_sel) || (state_reg == ST_HOLD);
    assign cpu_hold   = (state_reg == ST_HOLD);
    assign cpu_rdata  = mem_rdata;
    assign host_ack   = host_ack_reg;
    assign host_rdata = host_rdata_reg;

    always_comb begin
        if (grant_host) begin
            mem_sel   = 1'b1;
            mem_we    = lat_we_reg;
            mem_addr  = lat_addr_reg;
            mem_wdata = lat_wdata_reg;
        end else begin
            mem_sel   = cpu_sel;
            mem_we    = cpu_sel & cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            host_ack_reg   <= 1'b0;
            host_rdata_reg <= '0;
            lat_we_reg     <= 1'b0;
            lat_addr_reg   <= '0;
            lat_wdata_reg  <= '0;
        end else begin
            host_ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (host_req) begin
                        lat_we_reg    <= host_we;
                        lat_addr_reg  <= host_addr;
                        lat_wdata_reg <= host_wdata;
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!cpu_sel) begin
                        if (!lat_we_reg) begin
                            host_rdata_reg <= mem_rdata;
                        end
                        cnt_reg      <= '0;
                        host_ack_reg <= 1'b1;
                        state_reg    <= ST_DONE;
                    end else if (cnt_reg == CNT_W'(STARVE_MAX - 1)) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_HOLD;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // The CPU is frozen this cycle, so the host owns the port whatever cpu_sel says
                    if (!lat_we_reg) begin
                        host_rdata_reg <= mem_rdata;
                    end
                    host_ack_reg <= 1'b1;
                    state_reg    <= ST_DONE;
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbus_arb.sv
// Scoreboard bench for xbus_arb: expected writes, holds and acks are queued when a request is issued.
// A negedge monitor pops and compares them when the DUT produces them.
module tb_xbus_arb;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 8;
    localparam int CNT_W      = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_sel = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hold;
    logic              host_req = 1'b0;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_sel;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    xbus_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_sel && mem_we) mem[mem_addr] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ev_t;

    ev_t ack_q[$];
    ev_t wr_q[$];
    ev_t hold_q[$];
    logic [DATA_W-1:0] model_mem [int];
    logic [DATA_W-1:0] exp_rdata = '0;
    int pass_cnt  = 0;
    int total_cnt = 0;

    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            if (host_ack) begin
                $display("xfer ack cyc=%0d rdata=%h", cyc, host_rdata);
                total_cnt++;
                if (ack_q.size() == 0) begin
                    $display("FAIL ack_unexpected: host_ack=1 at cyc=%0d, required no ack", cyc);
                end else begin
                    e = ack_q.pop_front();
                    if (cyc !== e.cyc || host_rdata !== e.data)
                        $display("FAIL ack: got cyc=%0d rdata=%h, required cyc=%0d rdata=%h",
                                 cyc, host_rdata, e.cyc, e.data);
                    else pass_cnt++;
                end
            end
            if (mem_sel && mem_we) begin
                total_cnt++;
                if (wr_q.size() == 0) begin
                    $display("FAIL wr_unexpected: write addr=%h at cyc=%0d, required none", mem_addr, cyc);
                end else begin
                    e = wr_q.pop_front();
                    if (cyc !== e.cyc || mem_addr !== e.addr || mem_wdata !== e.data)
                        $display("FAIL wr: got cyc=%0d addr=%h data=%h, required cyc=%0d addr=%h data=%h",
                                 cyc, mem_addr, mem_wdata, e.cyc, e.addr, e.data);
                    else pass_cnt++;
                end
            end
            if (cpu_hold) begin
                total_cnt++;
                if (hold_q.size() == 0) begin
                    $display("FAIL hold_unexpected: cpu_hold=1 at cyc=%0d, required 0", cyc);
                end else begin
                    e = hold_q.pop_front();
                    if (cyc !== e.cyc || mem_sel !== 1'b1 || mem_addr !== e.addr)
                        $display("FAIL hold: got cyc=%0d mem_sel=%b addr=%h, required cyc=%0d mem_sel=1 addr=%h",
                                 cyc, mem_sel, mem_addr, e.cyc, e.addr);
                    else pass_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, output int lat);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        lat = cyc;
    endtask

    task automatic wait_ack(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (host_ack === 1'b1) begin
                ok = 1'b1;
                host_req = 1'b0;
                break;
            end
        end
        host_req = 1'b0;
    endtask

    task automatic push_ev(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input int which);
        ev_t e;
        e.cyc = c; e.addr = a; e.data = d;
        if (which == 0) ack_q.push_back(e);
        else if (which == 1) wr_q.push_back(e);
        else hold_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (host_ack !== 1'b0) $display("FAIL reset_ack: got %b required 0", host_ack); else pass_cnt++;
        total_cnt++; if (cpu_hold !== 1'b0) $display("FAIL reset_hold: got %b required 0", cpu_hold); else pass_cnt++;
        total_cnt++; if (host_rdata !== '0) $display("FAIL reset_rdata: got %h required 0", host_rdata); else pass_cnt++;
        total_cnt++; if (mem_sel !== 1'b0) $display("FAIL reset_mem_sel: got %b required 0", mem_sel); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b required 0", mem_we); else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    task automatic finish_checks(input string name, input bit ok);
        total_cnt++;
        if (!ok) $display("FAIL %s_timeout: host_ack never seen, required within budget", name);
        else pass_cnt++;
        total_cnt++;
        if (ack_q.size() + wr_q.size() + hold_q.size() !== 0)
            $display("FAIL %s_pending: got %0d/%0d/%0d outstanding ack/wr/hold, required 0/0/0",
                     name, ack_q.size(), wr_q.size(), hold_q.size());
        else pass_cnt++;
    endtask

    task automatic test_host_write();
        int L; bit ok;
        cpu_sel = 1'b0;
        tick();
        start_req(1'b1, 11'h010, 32'hDEADBEEF, L);
        push_ev(L + 1, 11'h010, 32'hDEADBEEF, 1);
        model_mem[32'h010] = 32'hDEADBEEF;
        push_ev(L + 2, '0, exp_rdata, 0);
        tick();
        host_we = 1'b0; host_addr = 11'h3FF; host_wdata = 32'h0;
        wait_ack(10, ok);
        repeat (2) tick();
        finish_checks("host_write", ok);
    endtask

    task automatic test_host_read();
        int L; bit ok;
        cpu_sel = 1'b0;
        tick();
        start_req(1'b0, 11'h010, 32'h0, L);
        exp_rdata = model_mem[32'h010];
        push_ev(L + 2, '0, exp_rdata, 0);
        wait_ack(10, ok);
        host_addr = 11'h055;
        repeat (5) tick();
        total_cnt++;
        if (host_rdata !== exp_rdata)
            $display("FAIL read_held: got %h required %h", host_rdata, exp_rdata);
        else pass_cnt++;
        finish_checks("host_read", ok);
    endtask

    task automatic test_toggle();
        int L; bit ok;
        tick();
        cpu_sel = 1'b1; cpu_addr = 11'h7FF;
        start_req(1'b1, 11'h040, 32'hCAFEF00D, L);
        model_mem[32'h040] = 32'hCAFEF00D;
        push_ev(L + 3, 11'h040, 32'hCAFEF00D, 1);
        push_ev(L + 4, '0, exp_rdata, 0);
        tick();
        tick();
        tick();
        cpu_sel = 1'b0;
        wait_ack(10, ok);
        repeat (2) tick();
        finish_checks("toggle", ok);
    endtask

    task automatic test_starve();
        int L; bit ok;
        tick();
        cpu_sel = 1'b1; cpu_addr = 11'h7FE;
        start_req(1'b1, 11'h020, 32'h12345678, L);
        model_mem[32'h020] = 32'h12345678;
        push_ev(L + STARVE_MAX + 1, 11'h020, '0, 2);
        push_ev(L + STARVE_MAX + 1, 11'h020, 32'h12345678, 1);
        push_ev(L + STARVE_MAX + 2, '0, exp_rdata, 0);
        tick();
        host_we = 1'b0; host_addr = 11'h111; host_wdata = 32'hFFFFFFFF;
        wait_ack(30, ok);
        repeat (3) tick();
        cpu_sel = 1'b0;
        finish_checks("starve", ok);
    endtask

    task automatic test_drop();
        int L; bit ok;
        tick();
        cpu_sel = 1'b1;
        start_req(1'b0, 11'h020, 32'h0, L);
        exp_rdata = model_mem[32'h020];
        push_ev(L + STARVE_MAX + 1, 11'h020, '0, 2);
        push_ev(L + STARVE_MAX + 2, '0, exp_rdata, 0);
        tick();
        host_req = 1'b0;
        wait_ack(30, ok);
        repeat (6) tick();
        cpu_sel = 1'b0;
        finish_checks("drop", ok);
    endtask

    task automatic test_async_reset();
        int L; bit ok;
        tick();
        cpu_sel = 1'b1;
        start_req(1'b0, 11'h020, 32'h0, L);
        repeat (6) tick();
        #2;
        rst = 1'b0; cpu_sel = 1'b0; host_req = 1'b0;
        #1;
        exp_rdata = '0;
        total_cnt++; if (cpu_hold !== 1'b0) $display("FAIL arst_hold: got %b required 0", cpu_hold); else pass_cnt++;
        total_cnt++; if (host_ack !== 1'b0) $display("FAIL arst_ack: got %b required 0", host_ack); else pass_cnt++;
        total_cnt++; if (host_rdata !== exp_rdata) $display("FAIL arst_rdata: got %h required %h", host_rdata, exp_rdata); else pass_cnt++;
        total_cnt++; if (mem_sel !== 1'b0) $display("FAIL arst_mem_sel: got %b required 0", mem_sel); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL arst_mem_we: got %b required 0", mem_we); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        start_req(1'b1, 11'h030, 32'hA5A50F0F, L);
        model_mem[32'h030] = 32'hA5A50F0F;
        push_ev(L + 1, 11'h030, 32'hA5A50F0F, 1);
        push_ev(L + 2, '0, exp_rdata, 0);
        wait_ack(10, ok);
        repeat (2) tick();
        finish_checks("post_reset", ok);
    endtask

    initial begin
        test_reset();
        test_host_write();
        test_host_read();
        test_toggle();
        test_starve();
        test_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/xbus_arb.md
Name: xbus_arb

Overview:
- Arbiter sharing the single data-memory port between the CPU controller's data bus and an external host/debug requester.
- CPU has fixed priority. The host is served in CPU idle cycles.
- A starvation counter forces a one-cycle CPU hold so the host is guaranteed service within STARVE_MAX+2 cycles.
- Sits between the CPU data port and the data memory / register file.

Parameters:
- ADDR_W, 11, data address width (matches the CPU data_addr width).
- DATA_W, 32, data word width.
- STARVE_MAX, 8, consecutive CPU-busy cycles tolerated before a forced hold (legal range 1..2^CNT_W-1).
- CNT_W, 4, starvation counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_sel  in  1  CPU data access request (the CPU's data_sel)
- cpu_we  in  1  CPU write enable
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data to CPU
- cpu_hold  out  1  CPU must freeze pc/registers this cycle
- host_req  in  1  host request; held high until host_ack
- host_we  in  1  host write enable
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DATA_W  registered host read data, valid with host_ack and held afterwards
- mem_sel  out  1  memory select
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational read)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: state=IDLE, cnt=0, host_ack=0, host_rdata=0, cpu_hold=0, latched host request registers=0.
- States: IDLE, WAIT, HOLD, DONE. Encoding is free.
- IDLE: if host_req=1, latch host_we/host_addr/host_wdata and go to WAIT. Otherwise stay.
- WAIT, cpu_sel=0: host granted this cycle. If latched we=0, capture mem_rdata into host_rdata at the edge. Go to DONE, cnt<=0.
- WAIT, cpu_sel=1: CPU granted.
  - If cnt==STARVE_MAX-1, go to HOLD, cnt<=0.
  - Else cnt<=cnt+1 and stay in WAIT.
- HOLD: cpu_hold=1 (combinational from state). Host granted unconditionally, whatever cpu_sel is. Read capture as in WAIT. Go to DONE.
- DONE: host_ack=1 for exactly this cycle. Go to IDLE. host_req is ignored in DONE.
  - Max throughput is one host transfer per 3 cycles.
- Grant mux: grant_host = (WAIT & ~cpu_sel) | HOLD.
  - grant_host=1: mem_sel=1, mem_we=latched we, mem_addr/mem_wdata from latched registers.
  - grant_host=0: mem_sel=cpu_sel, mem_we=cpu_sel&cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - mem_addr/mem_wdata always driven from the selected source, never X.
- cpu_rdata = mem_rdata at all times. The CPU discards it while cpu_hold=1.
- A host request is committed once latched. Dropping host_req in WAIT/HOLD does not cancel it; the transfer completes and host_ack still pulses.
- Host inputs changing after the latch cycle have no effect on the transfer.
- Memory write is observed at the clock edge of the grant cycle. host_ack follows one cycle later.
- Worst-case host latency from latch to ack: STARVE_MAX+2 cycles.
- Reset asserted mid-transfer: immediate return to IDLE, no ack, pending request lost. cpu_hold deasserts asynchronously.
- cnt never exceeds STARVE_MAX-1. No wrap-around is possible within the legal parameter range.

Test Plan:
- Reset, then cpu_sel=0, host_req=1, host_we=1, addr=0x010, wdata=0xDEADBEEF: mem_we=1 at addr 0x010 in cycle 2, host_ack in cycle 3, cpu_hold never high.
- Host read of addr 0x010 (memory holds 0xDEADBEEF) with CPU idle: host_rdata=0xDEADBEEF with host_ack, still held 5 cycles later.
- cpu_sel=1 continuously, STARVE_MAX=8, host write request: cpu_hold=1 for exactly one cycle, 9 cycles after latch, with mem_sel/mem_addr from the host. host_ack on the next cycle. No cpu_hold otherwise.
- cpu_sel toggling 1,1,0 during WAIT: host granted in the third WAIT cycle, no hold, cnt returns to 0.
- Host drops host_req one cycle after latch while the CPU is busy: transfer still completes, exactly one host_ack pulse.
- rst driven low asynchronously while in WAIT (cnt=5): all outputs 0 immediately, state IDLE. After release, a new request completes normally.
